neuron_update_scheduler: RTL
============================

# neuron_update_scheduler

Time-multiplexes one shared `potential_adder` datapath among `NUM_NEURONS` neurons of the 10-neuron accelerator. It holds every neuron's membrane potential in an internal register file and arbitrates weight requests round-robin. Each granted request is issued to the adder with the neuron's stored potential, and the adder's result and spike are written back. A timestep FSM brackets accumulation, drains in-flight operations and reports the timestep's spike vector.

## Interface
Parameters:
- `NUM_NEURONS`, 10: neurons served; index width `IDX_W = $clog2(NUM_NEURONS)`.
- `DATA_W`, 32: IEEE-754 single-precision word width.
- `ADDER_LAT`, 1: fixed cycles from issue to adder result (≥1).
- `RESET_POT`, 32'h0000_0000: potential loaded at reset.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RESET_N`  in  1: asynchronous, active-low reset.
- `ts_start`  in  1: pulse, begins a timestep.
- `ts_end`  in  1: pulse, stops accepting weights for this timestep.
- `wt_req`  in  NUM_NEURONS: per-neuron weight pending.
- `wt_data`  in  NUM_NEURONS*DATA_W: packed weights; neuron i at `[i*DATA_W +: DATA_W]`.
- `wt_gnt`  out  NUM_NEURONS: one-hot grant; the weight is consumed in the grant cycle.
- `adder_valid`  out  1: issue strobe to the adder.
- `adder_weight`  out  DATA_W: to `input_weight`.
- `adder_potential`  out  DATA_W: to `decayed_potential`.
- `adder_result`  in  DATA_W: `final_potential`, valid `ADDER_LAT` cycles after issue.
- `adder_spike`  in  1: spike, aligned with `adder_result`.
- `pot_rd_idx`  in  IDX_W: potential readback select.
- `pot_rd_data`  out  DATA_W: combinational readback of the register file.
- `spike_vec`  out  NUM_NEURONS: spikes of the last completed timestep.
- `ts_done`  out  1: one-cycle pulse when a timestep completes.
- `sched_busy`  out  1: high in any state except IDLE.

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE → ACCUM on `ts_start`. Entering ACCUM clears the internal spike accumulator `spike_acc`.
- ACCUM → DRAIN on `ts_end`.
- DRAIN → DONE when no operation is in flight.
- DONE → IDLE after one cycle. In DONE, `spike_vec <= spike_acc` and `ts_done = 1`.
- `ts_start` outside IDLE is ignored.
- `ts_end` outside ACCUM is ignored.
- If `ts_start` and `ts_end` arrive together in IDLE, start is taken and end is ignored.
- Eligibility: `wt_req[i] & ~busy[i]`. `busy[i]` is set at issue and cleared at writeback, so a neuron never has two operations in flight.
- Arbitration is round-robin. Search starts at `last_gnt+1` mod NUM_NEURONS. `last_gnt` resets to `NUM_NEURONS-1`, so neuron 0 has first priority.
- There is at most one grant per cycle, and grants occur only in ACCUM.
- `ts_end` suppresses any grant in the same cycle.
- Issue: `wt_gnt[i] = 1`, `adder_valid = 1`, `adder_weight = wt_data[i]`, `adder_potential = pot[i]`, all in the same cycle.
- When no grant is made, `adder_valid = 0` and the data outputs hold their last value.
- Writeback: an `ADDER_LAT`-deep shift register carries valid and index. When it emerges:
  - `pot[idx] <= adder_result`;
  - `spike_acc[idx] |= adder_spike`;
  - `busy[idx]` is cleared.
- Writebacks completing in DRAIN are still accumulated.
- Potentials persist across timesteps. Decay is applied upstream.

## Timing
- Reset values: FSM IDLE, `pot[*] = RESET_POT`, `busy = 0`, `spike_acc = 0`, `spike_vec = 0`, `ts_done = 0`, `wt_gnt = 0`, `adder_valid = 0`, `adder_weight = adder_potential = 0`, `sched_busy = 0`.
- Grant to writeback: `ADDER_LAT` cycles. A re-request from the same neuron is granted no earlier than cycle t+ADDER_LAT+1.
- With `ADDER_LAT = 1`, full throughput is one issue per cycle across different neurons.
- `ts_end` to `ts_done`: 1 cycle (DRAIN) plus the remaining in-flight latency, then DONE. The minimum is 2 cycles when nothing is in flight.
- `pot_rd_data` reflects a writeback in the cycle after it is written.
- Reset mid-operation: all state returns to reset values asynchronously. In-flight adder results are discarded.

## Structure
- Package `snn_sched_pkg`:
  - state enum `sched_state_t` (IDLE, ACCUM, DRAIN, DONE);
  - `FP_ZERO = 32'h0`;
  - default `NUM_NEURONS`.
- Sub-module `rr_arbiter`: parameter N; inputs `req[N]`, `en`; outputs one-hot `gnt[N]` and the pointer. The pointer updates only on a grant.
- Adder instantiation stays outside this block.

## Test plan
- Reset, then `ts_start` with `wt_req = 10'h3FF`, `ADDER_LAT = 1`, stub adder returning weight+1 → grants cycle through neurons 0..9 in order, one per cycle.
- Neuron 3 requests continuously and the stub asserts a spike → consecutive grants are at least 2 cycles apart; `pot[3]` updates each writeback; `spike_vec[3] = 1` after `ts_done`.
- Grant to neuron 7 in the cycle before `ts_end`, with `ADDER_LAT = 3` → DRAIN lasts until the writeback; `ts_done` follows 1 cycle later; the spike from that writeback is included.
- `ts_end` and `wt_req = 10'h001` in the same ACCUM cycle → `wt_gnt = 0`; the FSM goes to DRAIN and reaches DONE in 2 cycles.
- Second timestep with no spikes → `spike_vec` goes to `10'h000` at `ts_done`; potentials carry over from the previous timestep (check via `pot_rd_idx`).
- `RESET_N` low while 2 operations are in flight → `pot[*] = RESET_POT` and outputs at their reset values; no writeback occurs after reset release.

Source files
------------

// File: rtl/neuron_update_scheduler_pkg.sv
// Shared types and constants for the neuron update scheduler.
package snn_sched_pkg;

    localparam int NUM_NEURONS_DEF = 10;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/neuron_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
// The pointer (last winner) only moves when a grant is made.
module rr_arbiter
    import snn_sched_pkg::*;
#(
    parameter int N  = NUM_NEURONS_DEF,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] ptr
);

    localparam int CW = IW + 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [CW-1:0] cand;
    logic          found;

    // Walk candidates last+1 .. last+N (wrapped); the first eligible one wins.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (en && !found && req[cand[IW-1:0]]) begin
                found              = 1'b1;
                gnt[cand[IW-1:0]]  = 1'b1;
                ptr_d              = cand[IW-1:0];
            end
        end
    end

    // Pointer register; resets to N-1 so index 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/neuron_update_scheduler.sv
// Time-multiplexes one shared potential adder among NUM_NEURONS neurons.
// Holds the membrane potentials, arbitrates weight requests round-robin,
// writes adder results back and reports per-timestep spike vectors.
module neuron_update_scheduler
    import snn_sched_pkg::*;
#(
    parameter int                NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int                DATA_W      = 32,
    parameter int                ADDER_LAT   = 1,
    parameter logic [DATA_W-1:0] RESET_POT   = FP_ZERO,
    parameter int                IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          ts_start,
    input  logic                          ts_end,
    input  logic [NUM_NEURONS-1:0]        wt_req,
    input  logic [NUM_NEURONS*DATA_W-1:0] wt_data,
    output logic [NUM_NEURONS-1:0]        wt_gnt,
    output logic                          adder_valid,
    output logic [DATA_W-1:0]             adder_weight,
    output logic [DATA_W-1:0]             adder_potential,
    input  logic [DATA_W-1:0]             adder_result,
    input  logic                          adder_spike,
    input  logic [IDX_W-1:0]              pot_rd_idx,
    output logic [DATA_W-1:0]             pot_rd_data,
    output logic [NUM_NEURONS-1:0]        spike_vec,
    output logic                          ts_done,
    output logic                          sched_busy
);

    localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(NUM_NEURONS);

    sched_state_t             state_q, state_d;
    logic [DATA_W-1:0]        pot_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]   busy_q, busy_d;
    logic [NUM_NEURONS-1:0]   spike_acc_q, spike_acc_d;
    logic [NUM_NEURONS-1:0]   spike_vec_q, spike_vec_d;
    logic [DATA_W-1:0]        wt_hold_q, pot_hold_q;
    logic                     pipe_vld_q [ADDER_LAT];
    logic [IDX_W-1:0]         pipe_idx_q [ADDER_LAT];

    logic [DATA_W-1:0]        wt_word [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]   arb_gnt;
    logic [IDX_W-1:0]         last_gnt_unused;
    logic                     gnt_any;
    logic [IDX_W-1:0]         gnt_idx;
    logic                     wb_vld;
    logic [IDX_W-1:0]         wb_idx;
    logic [NUM_NEURONS-1:0]   wb_mask;
    logic                     drain_empty;

    // Grants only while accumulating, and never in the cycle ts_end arrives.
    rr_arbiter #(
        .N  (NUM_NEURONS),
        .IW (IDX_W)
    ) u_arb (
        .clk   (CLK),
        .rst_n (RESET_N),
        .req   (wt_req & ~busy_q),
        .en    ((state_q == ACCUM) && !ts_end),
        .gnt   (arb_gnt),
        .ptr   (last_gnt_unused)
    );

    // Unpack the weight bus and encode the one-hot grant into an index.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            wt_word[i] = wt_data[i*DATA_W +: DATA_W];
            if (arb_gnt[i]) begin
                gnt_idx = IDX_W'(i);
            end
        end
    end

    assign gnt_any = |arb_gnt;

    assign wb_vld = pipe_vld_q[ADDER_LAT-1];
    assign wb_idx = pipe_idx_q[ADDER_LAT-1];

    // Writeback mask, busy/spike bookkeeping and drain-complete look-ahead.
    always_comb begin
        wb_mask = '0;
        if (wb_vld) begin
            wb_mask[wb_idx] = 1'b1;
        end
        busy_d      = (busy_q & ~wb_mask) | arb_gnt;
        drain_empty = ((busy_q & ~wb_mask) == '0);
        spike_acc_d = spike_acc_q;
        if ((state_q == IDLE) && ts_start) begin
            spike_acc_d = '0;
        end else if (adder_spike) begin
            spike_acc_d = spike_acc_q | wb_mask;
        end
        spike_vec_d = (state_q == DONE) ? spike_acc_q : spike_vec_q;
    end

    // Timestep FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ts_start)    state_d = ACCUM;
            ACCUM:   if (ts_end)      state_d = DRAIN;
            DRAIN:   if (drain_empty) state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Control state, issue hold registers and the in-flight index pipeline.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            spike_acc_q <= '0;
            spike_vec_q <= '0;
            wt_hold_q   <= '0;
            pot_hold_q  <= '0;
            for (int i = 0; i < ADDER_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            spike_acc_q <= spike_acc_d;
            spike_vec_q <= spike_vec_d;
            if (gnt_any) begin
                wt_hold_q  <= wt_word[gnt_idx];
                pot_hold_q <= pot_q[gnt_idx];
            end
            pipe_vld_q[0] <= gnt_any;
            pipe_idx_q[0] <= gnt_idx;
            for (int i = 1; i < ADDER_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    // Potential register file; written only by emerging adder results.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i] <= RESET_POT;
            end
        end else if (wb_vld) begin
            pot_q[wb_idx] <= adder_result;
        end
    end

    assign wt_gnt          = arb_gnt;
    assign adder_valid     = gnt_any;
    assign adder_weight    = gnt_any ? wt_word[gnt_idx] : wt_hold_q;
    assign adder_potential = gnt_any ? pot_q[gnt_idx]   : pot_hold_q;
    assign pot_rd_data     = ({1'b0, pot_rd_idx} < N_LIM) ? pot_q[pot_rd_idx] : DATA_W'(FP_ZERO);
    assign spike_vec       = spike_vec_q;
    assign ts_done         = (state_q == DONE);
    assign sched_busy      = (state_q != IDLE);

endmodule
